// File: rtl/hilo_pkg.sv
// ----------------------------------------------------------------------------
// hilo_pkg
// Shared definitions for the HI/LO multiply-accumulate unit: operation
// encodings, FSM state encodings, datapath widths and small helpers used
// by the interface, the control FSM and the shift-add core.
// ----------------------------------------------------------------------------
package hilo_pkg;

    // Operand width and shift-add iteration count
    localparam int DATA_W   = 32;
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = $clog2(MUL_ITER);

    // Operation codes carried on OpIn
    typedef logic [2:0] op_t;
    localparam op_t OP_NONE  = 3'b000;
    localparam op_t OP_MULT  = 3'b001;
    localparam op_t OP_MULTU = 3'b010;
    localparam op_t OP_MADD  = 3'b011;
    localparam op_t OP_MSUB  = 3'b100;
    localparam op_t OP_MTHI  = 3'b101;
    localparam op_t OP_MTLO  = 3'b110;
    localparam op_t OP_RSVD  = 3'b111;

    // Control FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_SIGN = 2'd2;
    localparam state_t ST_WB   = 2'd3;

    // Signed multiply variants: the core works on magnitudes and the
    // product is negated afterwards when the operand signs differ.
    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/hi_lo_mac_unit_if.sv
// ----------------------------------------------------------------------------
// hi_lo_mac_unit_if
// Request/result bundle between the EX stage and the HI/LO unit.
//   StartIn  : request valid (from ID_EX)
//   OpIn     : operation code (hilo_pkg::OP_*)
//   RD1In    : rs operand
//   RD2In    : rt operand
//   FlushIn  : abort any in-flight operation
//   HiOut    : architectural HI register
//   LoOut    : architectural LO register
//   BusyOut  : stall request to the hazard unit
//   DoneOut  : one-cycle completion pulse
// master drives the request side, slave (the unit) drives the results.
// ----------------------------------------------------------------------------
interface hi_lo_mac_unit_if;
    import hilo_pkg::*;

    logic              StartIn;
    op_t               OpIn;
    logic [DATA_W-1:0] RD1In;
    logic [DATA_W-1:0] RD2In;
    logic              FlushIn;
    logic [DATA_W-1:0] HiOut;
    logic [DATA_W-1:0] LoOut;
    logic              BusyOut;
    logic              DoneOut;

    modport master (
        output StartIn,
        output OpIn,
        output RD1In,
        output RD2In,
        output FlushIn,
        input  HiOut,
        input  LoOut,
        input  BusyOut,
        input  DoneOut
    );

    modport slave (
        input  StartIn,
        input  OpIn,
        input  RD1In,
        input  RD2In,
        input  FlushIn,
        output HiOut,
        output LoOut,
        output BusyOut,
        output DoneOut
    );

endinterface

// File: rtl/hilo_mul_core.sv
// ----------------------------------------------------------------------------
// hilo_mul_core
// Radix-2 shift-add unsigned multiplier, one partial product per step.
//   Clk      : clock, rising edge
//   Rst      : asynchronous active-low reset
//   load_i   : capture operands, clear accumulator and iteration counter
//   step_i   : perform one shift-add iteration
//   clr_i    : discard the current operation (flush)
//   mcand_i  : multiplicand (unsigned magnitude)
//   mplier_i : multiplier (unsigned magnitude)
//   prod_o   : 64-bit accumulator, the full product after MUL_ITER steps
//   last_o   : the step being taken this cycle is the final one
// ----------------------------------------------------------------------------
module hilo_mul_core
    import hilo_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic                load_i,
    input  logic                step_i,
    input  logic                clr_i,
    input  logic [DATA_W-1:0]   mcand_i,
    input  logic [DATA_W-1:0]   mplier_i,
    output logic [2*DATA_W-1:0] prod_o,
    output logic                last_o
);

    logic [2*DATA_W-1:0] acc_q,    acc_d;
    logic [2*DATA_W-1:0] mcand_q,  mcand_d;
    logic [DATA_W-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            acc_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
            cnt_d    = '0;
        end else if (load_i) begin
            acc_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, mcand_i};
            mplier_d = mplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            // Multiplicand walks left while the multiplier walks right, so
            // bit 0 of the multiplier always selects the current weight.
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign prod_o = acc_q;
    assign last_o = step_i && (cnt_q == CNT_W'(MUL_ITER - 1));

endmodule

// File: rtl/hi_lo_mac_unit.sv
// ----------------------------------------------------------------------------
// hi_lo_mac_unit
// Multi-cycle HI/LO unit: MULT, MULTU, MADD, MSUB through a 32-step
// shift-add core, plus single-cycle MTHI/MTLO. A multiply accepted at
// edge k updates HI/LO at edge k+34 (1 load, 32 steps, 1 sign fix-up,
// 1 write-back is folded into the last edge).
//   Clk : clock, rising edge
//   Rst : asynchronous active-low reset
//   bus : hi_lo_mac_unit_if.slave
//         StartIn/OpIn/RD1In/RD2In/FlushIn in,
//         HiOut/LoOut/BusyOut/DoneOut out
// ----------------------------------------------------------------------------
module hi_lo_mac_unit
    import hilo_pkg::*;
(
    input  logic            Clk,
    input  logic            Rst,
    hi_lo_mac_unit_if.slave bus
);

    state_t                state_q, state_d;
    op_t                   op_q,    op_d;
    logic                  neg_q,   neg_d;
    logic [2*DATA_W-1:0]   prod_q,  prod_d;
    logic [DATA_W-1:0]     hi_q,    hi_d;
    logic [DATA_W-1:0]     lo_q,    lo_d;
    logic                  done_q,  done_d;

    logic                  core_load;
    logic                  core_step;
    logic                  core_clr;
    logic                  core_last;
    logic [2*DATA_W-1:0]   core_prod;
    logic                  op_signed;
    logic [DATA_W-1:0]     mag_rs;
    logic [DATA_W-1:0]     mag_rt;

    // Absolute value of a two's-complement operand when the op is signed;
    // the most negative value maps to 2^31, which is still exact unsigned.
    function automatic logic [DATA_W-1:0] magnitude(
        input logic signed [DATA_W-1:0] v,
        input logic                     use_sign
    );
        if (use_sign && (v < 0)) begin
            return $unsigned(-v);
        end
        return $unsigned(v);
    endfunction

    function automatic logic [2*DATA_W-1:0] apply_sign(
        input logic [2*DATA_W-1:0] p,
        input logic                neg
    );
        return neg ? (~p + 64'd1) : p;
    endfunction

    // All HI/LO arithmetic wraps modulo 2^64.
    function automatic logic [2*DATA_W-1:0] wb_result(
        input op_t                 op,
        input logic [2*DATA_W-1:0] hilo,
        input logic [2*DATA_W-1:0] p
    );
        case (op)
            OP_MADD: return hilo + p;
            OP_MSUB: return hilo - p;
            default: return p;
        endcase
    endfunction

    assign op_signed = is_signed_op(bus.OpIn);
    assign mag_rs    = magnitude(bus.RD1In, op_signed);
    assign mag_rt    = magnitude(bus.RD2In, op_signed);

    hilo_mul_core u_core (
        .Clk      (Clk),
        .Rst      (Rst),
        .load_i   (core_load),
        .step_i   (core_step),
        .clr_i    (core_clr),
        .mcand_i  (mag_rs),
        .mplier_i (mag_rt),
        .prod_o   (core_prod),
        .last_o   (core_last)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_d     = neg_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
        core_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A flush in the same cycle wins: nothing is accepted.
                if (bus.StartIn && !bus.FlushIn) begin
                    case (bus.OpIn)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                            core_load = 1'b1;
                            op_d      = bus.OpIn;
                            neg_d     = op_signed &&
                                        (bus.RD1In[DATA_W-1] ^ bus.RD2In[DATA_W-1]);
                            state_d   = ST_MUL;
                        end
                        OP_MTHI: begin
                            hi_d   = bus.RD1In;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.RD1In;
                            done_d = 1'b1;
                        end
                        OP_NONE, OP_RSVD: begin
                        end
                    endcase
                end
            end

            ST_MUL: begin
                if (bus.FlushIn) begin
                    core_clr = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    if (core_last) begin
                        state_d = ST_SIGN;
                    end
                end
            end

            ST_SIGN: begin
                if (bus.FlushIn) begin
                    core_clr = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    prod_d  = apply_sign(core_prod, neg_q);
                    state_d = ST_WB;
                end
            end

            ST_WB: begin
                // Flush here drops the write and the completion pulse.
                if (!bus.FlushIn) begin
                    {hi_d, lo_d} = wb_result(op_q, {hi_q, lo_q}, prod_q);
                    done_d       = 1'b1;
                end
                core_clr = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
            neg_q   <= 1'b0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.HiOut   = hi_q;
    assign bus.LoOut   = lo_q;
    assign bus.BusyOut = (state_q != ST_IDLE);
    assign bus.DoneOut = done_q;

endmodule

// File: tb/tb_hi_lo_mac_unit.sv
// ----------------------------------------------------------------------------
// tb_hi_lo_mac_unit
// Directed bench for hi_lo_mac_unit with a transaction-level reference
// model (64-bit arithmetic plus a latency countdown) compared every cycle,
// and literal expectations for the named scenarios.
// ----------------------------------------------------------------------------
module tb_hi_lo_mac_unit;
    import hilo_pkg::*;

    logic Clk = 1'b0;
    logic Rst = 1'b0;

    hi_lo_mac_unit_if bus();

    hi_lo_mac_unit dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // ------------------------------------------------------------------
    // Reference model: HI/LO values, result pending write, cycles left
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [63:0] pend;
        logic [6:0]  left;
        logic        done;
    } mstate_t;

    mstate_t ms = '0;

    function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input logic start,
                                           input logic flush, input op_t op,
                                           input logic [31:0] a, input logic [31:0] b);
        mstate_t     n;
        logic [63:0] hl;
        n      = s;
        hl     = {s.hi, s.lo};
        n.done = 1'b0;
        if (s.left != 7'd0) begin
            if (flush) begin
                n.left = 7'd0;
            end else begin
                n.left = s.left - 7'd1;
                if (n.left == 7'd0) begin
                    {n.hi, n.lo} = s.pend;
                    n.done       = 1'b1;
                end
            end
        end else if (start && !flush) begin
            case (op)
                OP_MULT:  begin n.pend = product(a, b, 1'b1);      n.left = 7'd34; end
                OP_MULTU: begin n.pend = product(a, b, 1'b0);      n.left = 7'd34; end
                OP_MADD:  begin n.pend = hl + product(a, b, 1'b1); n.left = 7'd34; end
                OP_MSUB:  begin n.pend = hl - product(a, b, 1'b1); n.left = 7'd34; end
                OP_MTHI:  begin n.hi = a; n.done = 1'b1; end
                OP_MTLO:  begin n.lo = a; n.done = 1'b1; end
                default:  begin end
            endcase
        end
        return n;
    endfunction

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ms <= '0;
        end else begin
            ms <= model_step(ms, bus.StartIn, bus.FlushIn, bus.OpIn, bus.RD1In, bus.RD2In);
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("cyc_hi",   64'(bus.HiOut),   64'(ms.hi));
            chk("cyc_lo",   64'(bus.LoOut),   64'(ms.lo));
            chk("cyc_busy", 64'(bus.BusyOut), 64'(ms.left != 7'd0));
            chk("cyc_done", 64'(bus.DoneOut), 64'(ms.done));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic op_run(input op_t op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n, output int done_n);
        @(negedge Clk);
        bus.StartIn = 1'b1;
        bus.OpIn    = op;
        bus.RD1In   = a;
        bus.RD2In   = b;
        busy_n      = 0;
        done_n      = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            bus.StartIn = 1'b0;
            bus.OpIn    = OP_NONE;
            if (bus.BusyOut) busy_n++;
            if (bus.DoneOut) done_n++;
        end
    endtask

    task automatic expect_op(input string name, input op_t op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input int exp_busy,
                             input int exp_done);
        int busy_n;
        int done_n;
        op_run(op, a, b, busy_n, done_n);
        chk({name, "_hi"},   64'(bus.HiOut), 64'(exp_hi));
        chk({name, "_lo"},   64'(bus.LoOut), 64'(exp_lo));
        chk({name, "_busy"}, 64'(busy_n),    64'(exp_busy));
        chk({name, "_done"}, 64'(done_n),    64'(exp_done));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_n;
        int done_n;

        bus.StartIn = 1'b0;
        bus.OpIn    = OP_NONE;
        bus.RD1In   = '0;
        bus.RD2In   = '0;
        bus.FlushIn = 1'b0;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_hi",   64'(bus.HiOut),   64'h0);
        chk("rst_lo",   64'(bus.LoOut),   64'h0);
        chk("rst_busy", 64'(bus.BusyOut), 64'h0);
        chk("rst_done", 64'(bus.DoneOut), 64'h0);
        Rst    = 1'b1;
        chk_en = 1'b1;

        // Signed / unsigned products
        expect_op("mult_m1x2",   OP_MULT,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1);
        expect_op("multu_m1x2",  OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 34, 1);
        expect_op("mult_minsq",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 34, 1);
        expect_op("multu_maxsq", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 34, 1);

        // Moves and accumulate
        expect_op("mthi_0",  OP_MTHI, 32'h0, 32'h0, 32'h0, 32'h1, 0, 1);
        expect_op("mtlo_5",  OP_MTLO, 32'h5, 32'h0, 32'h0, 32'h5, 0, 1);
        expect_op("madd_34", OP_MADD, 32'h3, 32'h4, 32'h0, 32'h11, 34, 1);
        expect_op("msub_73", OP_MSUB, 32'h7, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFC, 34, 1);

        // Ignored opcodes
        expect_op("op_none", OP_NONE, 32'h1234, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFC, 0, 0);
        expect_op("op_111",  OP_RSVD, 32'h1234, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFC, 0, 0);

        // Flush beats start in IDLE
        @(negedge Clk);
        bus.StartIn = 1'b1;
        bus.FlushIn = 1'b1;
        bus.OpIn    = OP_MTLO;
        bus.RD1In   = 32'h77;
        @(negedge Clk);
        bus.StartIn = 1'b0;
        bus.FlushIn = 1'b0;
        chk("idleflush_lo",   64'(bus.LoOut),   64'hFFFFFFFC);
        chk("idleflush_done", 64'(bus.DoneOut), 64'h0);

        // Flush at iteration 10, with a competing start in the same cycle
        @(negedge Clk);
        bus.StartIn = 1'b1;
        bus.OpIn    = OP_MULT;
        bus.RD1In   = 32'h12345678;
        bus.RD2In   = 32'h9;
        @(negedge Clk);
        bus.StartIn = 1'b0;
        repeat (10) @(negedge Clk);
        chk("flush10_busy_before", 64'(bus.BusyOut), 64'h1);
        bus.FlushIn = 1'b1;
        bus.StartIn = 1'b1;
        bus.RD1In   = 32'h2;
        bus.RD2In   = 32'h3;
        @(negedge Clk);
        bus.FlushIn = 1'b0;
        bus.StartIn = 1'b0;
        chk("flush10_busy_after", 64'(bus.BusyOut), 64'h0);
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (bus.BusyOut) busy_n++;
            if (bus.DoneOut) done_n++;
        end
        chk("flush10_busy_n", 64'(busy_n), 64'h0);
        chk("flush10_done_n", 64'(done_n), 64'h0);
        chk("flush10_hi", 64'(bus.HiOut), 64'hFFFFFFFF);
        chk("flush10_lo", 64'(bus.LoOut), 64'hFFFFFFFC);

        // Flush during write-back suppresses the write
        @(negedge Clk);
        bus.StartIn = 1'b1;
        bus.OpIn    = OP_MADD;
        bus.RD1In   = 32'h1;
        bus.RD2In   = 32'h1;
        @(negedge Clk);
        bus.StartIn = 1'b0;
        repeat (33) @(negedge Clk);
        chk("wbflush_busy_before", 64'(bus.BusyOut), 64'h1);
        bus.FlushIn = 1'b1;
        @(negedge Clk);
        bus.FlushIn = 1'b0;
        chk("wbflush_busy", 64'(bus.BusyOut), 64'h0);
        chk("wbflush_done", 64'(bus.DoneOut), 64'h0);
        chk("wbflush_lo",   64'(bus.LoOut),   64'hFFFFFFFC);

        // Asynchronous reset in the middle of MUL
        @(negedge Clk);
        bus.StartIn = 1'b1;
        bus.OpIn    = OP_MULT;
        bus.RD1In   = 32'h11111111;
        bus.RD2In   = 32'h3;
        @(negedge Clk);
        bus.StartIn = 1'b0;
        repeat (5) @(negedge Clk);
        #1 Rst = 1'b0;
        #1;
        chk("arst_hi",   64'(bus.HiOut),   64'h0);
        chk("arst_lo",   64'(bus.LoOut),   64'h0);
        chk("arst_busy", 64'(bus.BusyOut), 64'h0);
        #2 Rst = 1'b1;
        expect_op("mult_6x7", OP_MULT, 32'h6, 32'h7, 32'h0, 32'h2A, 34, 1);

        // Start held during a busy operation
        @(negedge Clk);
        bus.StartIn = 1'b1;
        bus.OpIn    = OP_MULT;
        bus.RD1In   = 32'h5;
        bus.RD2In   = 32'h5;
        busy_n      = 0;
        done_n      = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                bus.RD1In = 32'h2;
                bus.RD2In = 32'h2;
            end
            if (i == 38) bus.StartIn = 1'b0;
            if (bus.BusyOut) busy_n++;
            if (bus.DoneOut) done_n++;
        end
        chk("held_busy_n", 64'(busy_n),    64'd68);
        chk("held_done_n", 64'(done_n),    64'd2);
        chk("held_hi",     64'(bus.HiOut), 64'h0);
        chk("held_lo",     64'(bus.LoOut), 64'h4);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
